// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the command-byte UART transmitter.
// Imported by uart_cmd_tx and uart_baud_gen.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam int FRAME_BITS = 10;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Emits bit_tick on the last clock of each bit period.
module uart_baud_gen
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int W = clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign bit_tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Sends CMD_BYTE as one 8N1 frame per rising edge of cmd_level.
// busy covers the frame in flight plus a one-deep pending trigger.
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          BAUD         = 115_200,
    parameter logic [7:0]  CMD_BYTE     = 8'h53,
    parameter int          CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_level,
    output logic uart_txd,
    output logic busy,
    output logic done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $fatal(1, "uart_cmd_tx: CLKS_PER_BIT must be >= 2");
    end

    logic s1_q, s2_q, s3_q;
    logic trig;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic       pending_q, pending_d;
    logic       busy_q, busy_d;
    logic       txd_q, txd_d;
    logic       start_frame;
    logic       bit_tick;

    // s1/s2 resynchronise the PIO level; s3 turns it into a rising-edge strobe
    assign trig = s2_q & ~s3_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q != IDLE),
        .clr     (start_frame),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        pending_d   = pending_q;
        start_frame = 1'b0;

        if (trig && state_q != IDLE) pending_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (trig || pending_q) begin
                    start_frame = 1'b1;
                    state_d     = START;
                    shift_d     = CMD_BYTE;
                    bit_d       = '0;
                    pending_d   = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // line level follows the state being entered so txd stays a clean flop output
        txd_d = 1'b1;
        if (state_d == START) txd_d = 1'b0;
        if (state_d == DATA)  txd_d = shift_d[0];

        busy_d = (state_d != IDLE) || pending_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            s1_q      <= cmd_level;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            txd_q     <= txd_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = busy_q;
    assign done     = (state_q == STOP) && bit_tick;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Scoreboard bench for uart_cmd_tx with a 4-clock bit period.
// Stimulus queues expected bytes; a line monitor decodes and checks frames.
module tb_uart_cmd_tx;

    localparam int         CPB  = 4;
    localparam logic [7:0] CMD  = 8'h53;
    localparam int         FLEN = 10 * CPB;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic cmd_level = 1'b0;
    logic uart_txd;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    logic       mon_prev = 1'b1;

    uart_cmd_tx #(
        .CLK_HZ      (50_000_000),
        .BAUD        (115_200),
        .CMD_BYTE    (CMD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_level(cmd_level),
        .uart_txd (uart_txd),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FLEN-1:0] exp_frame(input logic [7:0] b);
        logic [9:0]      bits;
        logic [FLEN-1:0] v;
        bits = {1'b1, b, 1'b0};
        v = '0;
        for (int j = 0; j < 10; j++)
            for (int s = 0; s < CPB; s++)
                v[j*CPB+s] = bits[j];
        return v;
    endfunction

    function automatic bit in_win(input int k, input int e);
        return (e > 0) && (k >= e) && (k < e + 3);
    endfunction

    // line monitor: one sample per clock on the falling edge
    initial begin
        logic [FLEN-1:0] tx_v, dn_v, bz_v, dn_exp, bz_exp;
        logic [7:0]      b;
        bit              aborted;
        int              st;
        dn_exp = '0;
        dn_exp[FLEN-1] = 1'b1;
        bz_exp = '1;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev = 1'b1;
            end else if (mon_prev && uart_txd === 1'b0) begin
                aborted = 0;
                st = cyc;
                tx_v = '0;
                dn_v = '0;
                bz_v = '0;
                for (int i = 0; i < FLEN; i++) begin
                    if (i > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1;
                        break;
                    end
                    tx_v[i] = uart_txd;
                    dn_v[i] = done;
                    bz_v[i] = busy;
                end
                mon_prev = 1'b1;
                if (!aborted) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", tx_v);
                    end else begin
                        b = exp_q.pop_front();
                        check("frame_bits", 64'(tx_v), 64'(exp_frame(b)));
                        check("frame_done", 64'(dn_v), 64'(dn_exp));
                        check("frame_busy", 64'(bz_v), 64'(bz_exp));
                    end
                end
            end else begin
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_done: got %b expected 0", done);
                end
                mon_prev = uart_txd;
            end
        end
    end

    task automatic run_frames(input string name, input int hold,
                              input int e1, input int e2, input int e3,
                              input int nexp, input int busy_exp);
        int t, k, rise_t;
        bit fin;
        t = 0;
        k = 0;
        rise_t = -1;
        fin = 0;
        for (int i = 0; i < nexp; i++) exp_q.push_back(CMD);
        cmd_level = 1'b1;
        while (!fin) begin
            @(negedge clk);
            t++;
            if (busy === 1'b1) begin
                if (k == 0) rise_t = t;
                k++;
            end else if (k > 0) begin
                fin = 1;
            end
            if ((k == 0 && t > 10) || k > 400) fin = 1;
            cmd_level = (t < hold) || in_win(k, e1) || in_win(k, e2)
                        || in_win(k, e3);
        end
        while (t < hold) begin
            @(negedge clk);
            t++;
        end
        cmd_level = 1'b0;
        check({name, "_latency"}, 64'(rise_t), 64'(3));
        check({name, "_busy_len"}, 64'(k), 64'(busy_exp));
        repeat (6) @(negedge clk);
    endtask

    task automatic check_gap(input string name);
        int n;
        n = start_q.size();
        if (n < 2) begin
            check({name, "_gap"}, 64'(n), 64'(2));
        end else begin
            check({name, "_gap"}, 64'(start_q[n-1] - start_q[n-2]),
                  64'(FLEN + 1));
        end
    endtask

    initial begin
        int t, k, bad;

        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_txd", 64'(uart_txd), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        run_frames("single", 3, 0, 0, 0, 1, FLEN);
        run_frames("held", 200, 0, 0, 0, 1, FLEN);
        run_frames("reraise", 3, 0, 0, 0, 1, FLEN);

        run_frames("pending", 3, 15, 0, 0, 2, 2 * FLEN + 1);
        check_gap("pending");

        run_frames("overflow", 3, 5, 12, 20, 2, 2 * FLEN + 1);

        // trigger strobe lands on the final STOP clock
        run_frames("stop_edge", 3, 38, 0, 0, 2, 2 * FLEN + 1);
        check_gap("stop_edge");

        // reset in the middle of a frame
        t = 0;
        k = 0;
        cmd_level = 1'b1;
        while (k < 18 && t < 40) begin
            @(negedge clk);
            t++;
            if (busy === 1'b1) k++;
            if (t >= 3) cmd_level = 1'b0;
        end
        check("midrst_reached", 64'(k), 64'(18));
        reset = 1'b1;
        @(negedge clk);
        check("midrst_txd", 64'(uart_txd), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("midrst_quiet", 64'(bad), 64'(0));

        repeat (10) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
